bus_dma: RTL and testbench
==========================

Name: bus_dma

Overview:
- Memory-bus initiator that copies a block of 32-bit words from a source address to a destination address.
- Drives the same sel/read/write-mask bus used by the on-chip responders (timer, RAM, UART).
- Started by a one-cycle command from the control logic. Reports busy while running and pulses done when finished.
- Moves one word at a time: a read transfer, then a write transfer, each completed by the responder's ready.

Parameters:
- COUNT_WIDTH, 16, width of the word-count input and the internal remaining-words counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle command; sampled in IDLE only
- src_in  input  32  source byte address; bits [1:0] ignored
- dst_in  input  32  destination byte address; bits [1:0] ignored
- count_in  input  COUNT_WIDTH  number of words to copy
- busy_out  output  1  high from the cycle after an accepted start until done pulses
- done_out  output  1  one-cycle pulse on completion
- address_out  output  32  bus address, always word-aligned ([1:0]=0)
- sel_out  output  1  bus select
- read_out  output  1  bus read strobe
- read_value_in  input  32  read data; valid in the cycle where sel_out & read_out & ready_in
- write_mask_out  output  4  byte enables; nonzero only during a write transfer
- write_value_out  output  32  write data
- ready_in  input  1  responder completes the current transfer in this cycle

Behaviour:
- Reset: state IDLE. busy_out, done_out, sel_out and read_out are 0. write_mask_out=0, address_out=0, write_value_out=0. Internal src, dst, remaining and data registers clear to 0.
- Reset mid-transfer aborts immediately; no done pulse is generated.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start_in with count_in!=0: latch {src_in[31:2],2'b0}, {dst_in[31:2],2'b0} and count_in, then go to READ.
  - start_in with count_in==0: go to DONE; no bus traffic.
- READ:
  - Outputs: sel_out=1, read_out=1, write_mask_out=0, address_out=src.
  - Held until ready_in=1. In that cycle, capture read_value_in into the data register and go to WRITE.
- WRITE:
  - Outputs: sel_out=1, read_out=0, write_mask_out=4'b1111, address_out=dst, write_value_out=data.
  - Held until ready_in=1. In that cycle: src+=4, dst+=4, remaining-=1.
  - Next state is DONE if remaining==1 before the decrement, otherwise READ.
- DONE: done_out=1 for exactly one cycle; busy_out=0; next state IDLE.
- Minimum cost is 2 cycles per word (ready_in tied high). Total for N words with zero wait states is 2N cycles of busy, plus the DONE cycle.
- Address arithmetic is modulo 2^32: 0xFFFFFFFC + 4 wraps to 0x00000000 silently.
- start_in is ignored outside IDLE. start_in in the same cycle as DONE is also ignored.
- ready_in is ignored in IDLE and DONE.
- Bus outputs must be registered-state driven (no combinational path from ready_in to sel_out).

Optional Feature:
- Macro BUS_DMA_FILL_EN.
- When defined:
  - Extra ports fill_in (1) and fill_value_in (32) are present.
  - start_in with fill_in=1 latches fill_value_in into the data register.
  - The transfer then skips READ entirely (IDLE→WRITE; WRITE→WRITE or DONE). src is unused.
- When undefined: the ports are absent and every transfer is a copy.

Decomposition:
- Package bus_dma_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - localparam WORD_BYTES=4;
  - localparam FULL_MASK=4'b1111.
- No sub-module; the FSM and counters are a single module.

Test Plan:
- Copy src=0x100, dst=0x200, count=3, ready_in tied 1 → 3 read/write pairs at 0x100/0x200, 0x104/0x204, 0x108/0x208. Data matches the model. done_out pulses on cycle 7 after start; busy high cycles 1-6.
- Wait states: ready_in low 2 cycles per transfer, count=2 → address/sel held stable while waiting. Total busy = 12 cycles; correct data.
- count=0, src=0x40 → no sel_out ever; done_out pulses the cycle after start.
- Unaligned and wrap: src=0xFFFFFFFD, count=2 → reads at 0xFFFFFFFC, then 0x00000000.
- Second start_in asserted mid-copy, and reset asserted during a WRITE wait → start ignored; after reset all outputs return to 0 next cycle with no done pulse.
- (BUS_DMA_FILL_EN) fill_in=1, fill_value_in=0xDEADBEEF, dst=0x300, count=4 → four writes of 0xDEADBEEF to 0x300-0x30C, read_out never asserted, done after 4 write cycles.

Source files
------------

// File: rtl/bus_dma_pkg.sv
// Shared types and constants for the bus_dma block-copy initiator.
package bus_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] FULL_MASK  = 4'b1111;

endpackage

// File: rtl/bus_dma.sv
// Word-by-word memory copy engine on the sel/read/write-mask responder bus.
// Optional constant-fill mode (no reads) is enabled with BUS_DMA_FILL_EN.
//
// state | meaning
// IDLE  | waiting for start_in
// READ  | reading the word at src, held until ready_in
// WRITE | writing the data register to dst, held until ready_in
// DONE  | one-cycle done pulse, then back to IDLE
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_in,
    input  logic [31:0]            src_in,
    input  logic [31:0]            dst_in,
    input  logic [COUNT_WIDTH-1:0] count_in,
`ifdef BUS_DMA_FILL_EN
    input  logic                   fill_in,
    input  logic [31:0]            fill_value_in,
`endif
    output logic                   busy_out,
    output logic                   done_out,
    output logic [31:0]            address_out,
    output logic                   sel_out,
    output logic                   read_out,
    input  logic [31:0]            read_value_in,
    output logic [3:0]             write_mask_out,
    output logic [31:0]            write_value_out,
    input  logic                   ready_in
);

    state_t                 state, state_next;
    logic [31:0]            src, dst, data;
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   fill_start;
    logic                   fill_mode;
    logic                   accept;

    // Byte-offset bits of the addresses are dropped on purpose.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_in[1:0], dst_in[1:0]};

    assign accept = (state == IDLE) && start_in && (count_in != '0);

`ifdef BUS_DMA_FILL_EN
    assign fill_start = fill_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_mode <= 1'b0;
        end else if (accept) begin
            fill_mode <= fill_in;
        end
    end
`else
    assign fill_start = 1'b0;
    assign fill_mode  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            data      <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        src       <= {src_in[31:2], 2'b00};
                        dst       <= {dst_in[31:2], 2'b00};
                        remaining <= count_in;
`ifdef BUS_DMA_FILL_EN
                        if (fill_in) begin
                            data <= fill_value_in;
                        end
`endif
                    end
                end
                READ: begin
                    if (ready_in) begin
                        data <= read_value_in;
                    end
                end
                WRITE: begin
                    if (ready_in) begin
                        src       <= src + 32'(WORD_BYTES);
                        dst       <= dst + 32'(WORD_BYTES);
                        remaining <= remaining - COUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs depend only on registered state, never on ready_in.
    always_comb begin
        state_next      = state;
        busy_out        = 1'b0;
        done_out        = 1'b0;
        sel_out         = 1'b0;
        read_out        = 1'b0;
        write_mask_out  = 4'b0000;
        address_out     = 32'h0;
        write_value_out = 32'h0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    if (count_in == '0) begin
                        state_next = DONE;
                    end else if (fill_start) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                busy_out    = 1'b1;
                sel_out     = 1'b1;
                read_out    = 1'b1;
                address_out = src;
                if (ready_in) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy_out        = 1'b1;
                sel_out         = 1'b1;
                write_mask_out  = FULL_MASK;
                address_out     = dst;
                write_value_out = data;
                if (ready_in) begin
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state_next = DONE;
                    end else if (fill_mode) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_dma.sv
// Self-checking bench for bus_dma: scoreboard of expected bus transfers.
module tb_bus_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_in;
    logic [31:0] src_in, dst_in;
    logic [15:0] count_in;
    logic        fill_in;
    logic [31:0] fill_value_in;
    logic        busy_out, done_out, sel_out, read_out, ready_in;
    logic [31:0] address_out, read_value_in, write_value_out;
    logic [3:0]  write_mask_out;

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int sel_cnt  = 0;
    int rd_cnt   = 0;
    int wait_n   = 0;
    int wait_ctr = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clk = ~clk;

    bus_dma dut (
        .clk            (clk),
        .reset          (reset),
        .start_in       (start_in),
        .src_in         (src_in),
        .dst_in         (dst_in),
        .count_in       (count_in),
`ifdef BUS_DMA_FILL_EN
        .fill_in        (fill_in),
        .fill_value_in  (fill_value_in),
`endif
        .busy_out       (busy_out),
        .done_out       (done_out),
        .address_out    (address_out),
        .sel_out        (sel_out),
        .read_out       (read_out),
        .read_value_in  (read_value_in),
        .write_mask_out (write_mask_out),
        .write_value_out(write_value_out),
        .ready_in       (ready_in)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
    endfunction

    // Responder model: data derived from the address, ready after wait_n stalls.
    assign read_value_in = pat(address_out);
    assign ready_in      = (wait_n == 0) || (wait_ctr == wait_n);

    always @(posedge clk) begin
        if (sel_out && !ready_in) wait_ctr <= wait_ctr + 1;
        else                      wait_ctr <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        xfer_t e;
        if (busy_out) busy_cnt++;
        if (done_out) done_cnt++;
        if (sel_out)  sel_cnt++;
        if (read_out) rd_cnt++;
        if (prev_wait && !reset) begin
            chk("hold_addr", address_out, prev_addr);
            chk("hold_sel", {31'b0, sel_out}, 32'd1);
        end
        prev_wait = sel_out && !ready_in;
        prev_addr = address_out;
        if (sel_out && ready_in) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {31'b0, sel_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_addr", address_out, e.addr);
                chk("xfer_rd", {31'b0, read_out}, {31'b0, e.rd});
                chk("xfer_mask", {28'b0, write_mask_out}, e.rd ? 32'd0 : 32'hF);
                if (!e.rd) chk("xfer_wdata", write_value_out, e.data);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_model(input logic [31:0] s, input logic [31:0] d,
                              input int n, input logic fill, input logic [31:0] fv);
        logic [31:0] sa, da;
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            if (!fill) exp_q.push_back('{rd: 1'b1, addr: sa, data: 32'h0});
            exp_q.push_back('{rd: 1'b0, addr: da, data: fill ? fv : pat(sa)});
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] s, input logic [31:0] d,
                       input int n, input logic fill, input logic [31:0] fv,
                       input int exp_done_cyc);
        int cyc, b0, s0, r0, d0;
        push_model(s, d, n, fill, fv);
        start_in = 1'b1; src_in = s; dst_in = d; count_in = 16'(n);
        fill_in = fill; fill_value_in = fv;
        b0 = busy_cnt; s0 = sel_cnt; r0 = rd_cnt; d0 = done_cnt;
        tick();
        start_in = 1'b0; fill_in = 1'b0;
        cyc = 1;
        while (!done_out && cyc < 300) begin
            tick();
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_done_cyc);
        tick();
        chk({tag, "_busy_cycles"}, busy_cnt - b0, (n == 0) ? 0 : exp_done_cyc - 1);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_q_empty"}, exp_q.size(), 0);
        if (n == 0) chk({tag, "_no_sel"}, sel_cnt - s0, 0);
        if (fill)   chk({tag, "_no_read"}, rd_cnt - r0, 0);
    endtask

    initial begin
        int guard, d0;
        reset = 1'b1; start_in = 1'b0; src_in = 0; dst_in = 0; count_in = 0;
        fill_in = 1'b0; fill_value_in = 0;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy_out}, 0);
        chk("rst_done", {31'b0, done_out}, 0);
        chk("rst_sel", {31'b0, sel_out}, 0);
        chk("rst_read", {31'b0, read_out}, 0);
        chk("rst_mask", {28'b0, write_mask_out}, 0);
        chk("rst_addr", address_out, 0);
        chk("rst_wdata", write_value_out, 0);
        reset = 1'b0;
        tick();

        wait_n = 0;
        run("copy3", 32'h100, 32'h200, 3, 1'b0, 32'h0, 7);
        wait_n = 2;
        run("wait2", 32'h2000, 32'h3000, 2, 1'b0, 32'h0, 13);
        wait_n = 0;
        run("count0", 32'h40, 32'h80, 0, 1'b0, 32'h0, 1);
        run("wrap", 32'hFFFF_FFFD, 32'h1000, 2, 1'b0, 32'h0, 5);

        // Mid-copy start must be ignored; reset during a write wait aborts.
        wait_n = 2;
        push_model(32'h500, 32'h600, 3, 1'b0, 32'h0);
        start_in = 1'b1; src_in = 32'h500; dst_in = 32'h600; count_in = 16'd3;
        tick();
        start_in = 1'b0;
        tick();
        start_in = 1'b1; src_in = 32'h900; dst_in = 32'hA00; count_in = 16'd5;
        tick();
        start_in = 1'b0;
        guard = 0;
        while (!(write_mask_out != 0 && !ready_in) && guard < 50) begin
            tick();
            guard++;
        end
        chk("abort_found_write_wait", {28'b0, write_mask_out}, 32'hF);
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        chk("abort_sel", {31'b0, sel_out}, 0);
        chk("abort_busy", {31'b0, busy_out}, 0);
        chk("abort_mask", {28'b0, write_mask_out}, 0);
        chk("abort_addr", address_out, 0);
        chk("abort_wdata", write_value_out, 0);
        reset = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_idle", {31'b0, busy_out}, 0);
        wait_n = 0;
        run("after_abort", 32'h700, 32'h800, 1, 1'b0, 32'h0, 3);

`ifdef BUS_DMA_FILL_EN
        run("fill4", 32'h0, 32'h300, 4, 1'b1, 32'hDEAD_BEEF, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
